// File: rtl/down_count_monitor_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | down_count_monitor_if                                                       |
// | Bus between a down-counter sampler and its legality monitor.                |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
interface down_count_monitor_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] cnt_in;
    logic             cnt_vld;
    logic             clear;
    logic             locked;
    logic             err_pulse;
    logic             wrap_pulse;
    logic             reload_pulse;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] wrap_cnt;

    modport master (
        output cnt_in, cnt_vld, clear,
        input  locked, err_pulse, wrap_pulse, reload_pulse, err_cnt, wrap_cnt
    );

    modport slave (
        input  cnt_in, cnt_vld, clear,
        output locked, err_pulse, wrap_pulse, reload_pulse, err_cnt, wrap_cnt
    );
endinterface
`default_nettype wire

// File: rtl/down_count_monitor.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | down_count_monitor                                                          |
// | Checks each sampled down-counter update is a decrement or reload to '1.     |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module down_count_monitor #(
    parameter int WIDTH  = 4,
    parameter int CNT_W  = 8,
    parameter int LOCK_N = 2
) (
    input  wire logic          clk,
    input  wire logic          rst,
    down_count_monitor_if.slave mon
);

    localparam int RUN_W = $clog2(LOCK_N + 1);

    localparam logic [WIDTH-1:0] c_all_ones = '1;
    localparam logic [WIDTH-1:0] c_val_zero = '0;
    localparam logic [WIDTH-1:0] c_val_one  = WIDTH'(1);
    localparam logic [RUN_W-1:0] c_run_one  = RUN_W'(1);
    localparam logic [RUN_W-1:0] c_lock_n   = RUN_W'(LOCK_N);
    localparam logic [CNT_W-1:0] c_cnt_max  = '1;
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    state_t           state_q,    state_d;
    logic [WIDTH-1:0] prev_q,     prev_d;
    logic [RUN_W-1:0] run_q,      run_d;
    logic             locked_q,   locked_d;
    logic             err_q,      err_d;
    logic             wrap_q,     wrap_d;
    logic             reload_q,   reload_d;
    logic [CNT_W-1:0] err_cnt_q,  err_cnt_d;
    logic [CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;

    logic [WIDTH-1:0] w_prev_dec;
    logic [RUN_W-1:0] w_run_inc;
    logic             w_legal;
    logic             w_reload;
    logic             w_wrap;

    // A 0 -> all-ones step is a legal decrement, so it never counts as a reload.
    assign w_prev_dec = prev_q - c_val_one;
    assign w_legal    = (mon.cnt_in == w_prev_dec);
    assign w_reload   = (mon.cnt_in == c_all_ones) && (prev_q != c_val_zero);
    assign w_wrap     = w_legal && (prev_q == c_val_zero);
    assign w_run_inc  = run_q + c_run_one;

    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        run_d    = run_q;
        err_d    = 1'b0;
        wrap_d   = 1'b0;
        reload_d = 1'b0;

        if (mon.cnt_vld) begin
            prev_d = mon.cnt_in;
            case (state_q)
                ST_IDLE: begin
                    run_d   = '0;
                    state_d = ST_ACQUIRE;
                end
                ST_ACQUIRE: begin
                    if (w_legal) begin
                        wrap_d = w_wrap;
                        run_d  = w_run_inc;
                        if (w_run_inc >= c_lock_n) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        run_d    = '0;
                        reload_d = w_reload;
                    end
                end
                ST_LOCKED: begin
                    if (w_legal) begin
                        wrap_d = w_wrap;
                    end else if (w_reload) begin
                        reload_d = 1'b1;
                    end else begin
                        err_d   = 1'b1;
                        run_d   = '0;
                        state_d = ST_ACQUIRE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        locked_d = (state_d == ST_LOCKED);

        // Clear takes precedence over a coincident increment.
        if (mon.clear) begin
            err_cnt_d  = '0;
            wrap_cnt_d = '0;
        end else begin
            err_cnt_d  = (err_d  && (err_cnt_q  != c_cnt_max)) ? err_cnt_q  + c_cnt_one : err_cnt_q;
            wrap_cnt_d = (wrap_d && (wrap_cnt_q != c_cnt_max)) ? wrap_cnt_q + c_cnt_one : wrap_cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            prev_q     <= '0;
            run_q      <= '0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
            wrap_q     <= 1'b0;
            reload_q   <= 1'b0;
            err_cnt_q  <= '0;
            wrap_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            run_q      <= run_d;
            locked_q   <= locked_d;
            err_q      <= err_d;
            wrap_q     <= wrap_d;
            reload_q   <= reload_d;
            err_cnt_q  <= err_cnt_d;
            wrap_cnt_q <= wrap_cnt_d;
        end
    end

    assign mon.locked       = locked_q;
    assign mon.err_pulse    = err_q;
    assign mon.wrap_pulse   = wrap_q;
    assign mon.reload_pulse = reload_q;
    assign mon.err_cnt      = err_cnt_q;
    assign mon.wrap_cnt     = wrap_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_down_count_monitor.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_down_count_monitor                                                       |
// | Directed plus random stimulus against a behavioural model of the monitor.   |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module tb_down_count_monitor;

    localparam int WIDTH  = 4;
    localparam int CNT_W  = 2;
    localparam int LOCK_N = 2;
    localparam int MODV   = 1 << WIDTH;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    down_count_monitor_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) mon ();

    down_count_monitor #(
        .WIDTH  (WIDTH),
        .CNT_W  (CNT_W),
        .LOCK_N (LOCK_N)
    ) dut (
        .clk (clk),
        .rst (rst),
        .mon (mon)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: "seen" = a sample exists since reset, "streak" = consecutive legal steps.
    bit m_seen;
    int m_prev;
    int m_streak;
    bit m_locked;
    bit m_err, m_wrap, m_reload;
    int m_err_cnt, m_wrap_cnt;
    int last_drv;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit v, input int d, input bit c);
        bit is_legal, is_reload;
        @(negedge clk);
        rst         = r;
        mon.cnt_vld = v;
        mon.cnt_in  = WIDTH'(d);
        mon.clear   = c;
        if (v) last_drv = d;
        @(posedge clk);
        m_err = 0; m_wrap = 0; m_reload = 0;
        if (r) begin
            m_seen = 0; m_prev = 0; m_streak = 0; m_locked = 0;
            m_err_cnt = 0; m_wrap_cnt = 0;
        end else begin
            if (v) begin
                if (!m_seen) begin
                    m_seen = 1; m_streak = 0; m_locked = 0;
                end else begin
                    is_legal  = (d == (m_prev + MODV - 1) % MODV);
                    is_reload = !is_legal && (d == MODV - 1) && (m_prev != 0);
                    if (is_legal) begin
                        m_wrap = (m_prev == 0);
                        if (!m_locked) begin
                            m_streak++;
                            if (m_streak >= LOCK_N) m_locked = 1;
                        end
                    end else if (is_reload) begin
                        m_reload = 1;
                        if (!m_locked) m_streak = 0;
                    end else begin
                        if (m_locked) m_err = 1;
                        m_locked = 0;
                        m_streak = 0;
                    end
                end
                m_prev = d;
            end
            if (c) begin
                m_err_cnt = 0; m_wrap_cnt = 0;
            end else begin
                if (m_err  && m_err_cnt  < CMAX) m_err_cnt++;
                if (m_wrap && m_wrap_cnt < CMAX) m_wrap_cnt++;
            end
        end
        #1;
        chk("locked",       8'(mon.locked),       8'(m_locked));
        chk("err_pulse",    8'(mon.err_pulse),    8'(m_err));
        chk("wrap_pulse",   8'(mon.wrap_pulse),   8'(m_wrap));
        chk("reload_pulse", 8'(mon.reload_pulse), 8'(m_reload));
        chk("err_cnt",      8'(mon.err_cnt),      8'(m_err_cnt));
        chk("wrap_cnt",     8'(mon.wrap_cnt),     8'(m_wrap_cnt));
    endtask

    task automatic feed(input int d);
        step(1'b0, 1'b1, d, 1'b0);
    endtask

    initial begin
        int sel, d;
        checks = 0; failures = 0; last_drv = 0;
        rst = 1'b1; mon.cnt_vld = 1'b0; mon.cnt_in = '0; mon.clear = 1'b0;

        // Reset held two cycles with valid toggling, then first sample seeds only.
        step(1'b1, 1'b1, 7, 1'b0);
        step(1'b1, 1'b0, 3, 1'b0);
        feed(15); feed(14); feed(13);
        for (int v = 12; v >= 0; v--) feed(v);
        feed(15); feed(14);

        // Illegal step while locked, relock, then a repeated value.
        step(1'b1, 1'b0, 0, 1'b0);
        feed(9); feed(8); feed(7); feed(5); feed(4); feed(3); feed(3);

        // Reload from a locked value.
        feed(2); feed(1); feed(6);
        feed(5); feed(4); feed(15); feed(14); feed(13);

        // Saturation, then clear coinciding with another error.
        for (int k = 0; k < 4; k++) begin
            feed(9); feed(8); feed(7); feed(2);
        end
        feed(1); feed(0);
        step(1'b0, 1'b1, 6, 1'b1);
        step(1'b0, 1'b0, 6, 1'b0);

        // Reset mid-lock with saturated error count.
        for (int k = 0; k < 4; k++) begin
            feed(9); feed(8); feed(7); feed(2);
        end
        feed(1); feed(0);
        step(1'b1, 1'b1, 5, 1'b0);
        feed(4); feed(3); feed(2); feed(1);

        // Randomised traffic biased toward legal steps and reloads.
        for (int n = 0; n < 2000; n++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 60)      d = (last_drv + MODV - 1) % MODV;
            else if (sel < 72) d = MODV - 1;
            else if (sel < 78) d = last_drv;
            else               d = int'($urandom_range(0, MODV - 1));
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 99) < 85),
                 d,
                 ($urandom_range(0, 99) < 4));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
